// File: rtl/pwm_capture_ip.sv
// PWM input capture: measures period (rise to rise) and high time (rise to fall) in clk cycles.
// Optional glitch filter compiled in with `define PWM_CAPTURE_GLITCH_FILTER_EN.
module pwm_capture_ip #(
  parameter int          CNT_WIDTH      = 32,
  parameter int          SYNC_STAGES    = 2,
  parameter int unsigned TIMEOUT_CYCLES = 32'd1_000_000,
  parameter int          FILTER_LEN     = 3
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 enable,
  input  logic                 clear,
  input  logic                 pwm_in,
  output logic [CNT_WIDTH-1:0] period_cycles_o,
  output logic [CNT_WIDTH-1:0] high_cycles_o,
  output logic                 meas_valid,
  output logic                 timeout,
  output logic                 level_o,
  output logic                 locked
);

  localparam logic [CNT_WIDTH-1:0] TO_LIM = CNT_WIDTH'(TIMEOUT_CYCLES);
  localparam logic [CNT_WIDTH-1:0] ONE    = CNT_WIDTH'(1);

  if (SYNC_STAGES < 2 || FILTER_LEN < 2) begin : g_param_check
    $error("pwm_capture_ip: SYNC_STAGES and FILTER_LEN must be at least 2");
  end

  typedef enum logic [1:0] {IDLE, ARM, HIGH, LOW} state_t;

  // Stage p0: metastability synchronizer
  logic [SYNC_STAGES-1:0] sync_p0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) sync_p0 <= '0;
    else     sync_p0 <= {sync_p0[SYNC_STAGES-2:0], pwm_in};
  end

  // Stage p1: optional glitch filter producing the conditioned level
  logic lvl;

`ifdef PWM_CAPTURE_GLITCH_FILTER_EN
  localparam int FLT_W = $clog2(FILTER_LEN);
  logic [FLT_W-1:0] flt_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lvl     <= 1'b0;
      flt_cnt <= '0;
    end else if (sync_p0[SYNC_STAGES-1] == lvl) begin
      flt_cnt <= '0;
    end else if (flt_cnt == FLT_W'(FILTER_LEN - 1)) begin
      lvl     <= sync_p0[SYNC_STAGES-1];
      flt_cnt <= '0;
    end else begin
      flt_cnt <= flt_cnt + FLT_W'(1);
    end
  end
`else
  assign lvl = sync_p0[SYNC_STAGES-1];
`endif

  // Stage p2: edge detection
  logic lvl_d;
  logic rise;
  logic fall;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) lvl_d <= 1'b0;
    else     lvl_d <= lvl;
  end

  assign rise    = lvl & ~lvl_d;
  assign fall    = ~lvl & lvl_d;
  assign level_o = lvl;

  // Stage p3: measurement FSM and registered results
  state_t               state, state_nxt;
  logic [CNT_WIDTH-1:0] cnt, cnt_nxt, cnt_inc;
  logic [CNT_WIDTH-1:0] high_lat, high_lat_nxt;
  logic [CNT_WIDTH-1:0] period_nxt, high_nxt;
  logic                 valid_nxt, timeout_nxt, locked_nxt;

  assign cnt_inc = cnt + ONE;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state           <= IDLE;
      cnt             <= '0;
      high_lat        <= '0;
      period_cycles_o <= '0;
      high_cycles_o   <= '0;
      meas_valid      <= 1'b0;
      timeout         <= 1'b0;
      locked          <= 1'b0;
    end else begin
      state           <= state_nxt;
      cnt             <= cnt_nxt;
      high_lat        <= high_lat_nxt;
      period_cycles_o <= period_nxt;
      high_cycles_o   <= high_nxt;
      meas_valid      <= valid_nxt;
      timeout         <= timeout_nxt;
      locked          <= locked_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    cnt_nxt      = cnt;
    high_lat_nxt = high_lat;
    period_nxt   = period_cycles_o;
    high_nxt     = high_cycles_o;
    valid_nxt    = 1'b0;
    timeout_nxt  = 1'b0;
    locked_nxt   = locked;

    if (!enable) begin
      state_nxt    = IDLE;
      cnt_nxt      = '0;
      high_lat_nxt = '0;
      locked_nxt   = 1'b0;
      if (clear) begin
        period_nxt = '0;
        high_nxt   = '0;
      end
    end else if (clear) begin
      // clear outranks any edge seen this cycle, so no report can slip out
      state_nxt    = ARM;
      cnt_nxt      = '0;
      high_lat_nxt = '0;
      period_nxt   = '0;
      high_nxt     = '0;
      locked_nxt   = 1'b0;
    end else begin
      case (state)
        IDLE: begin
          cnt_nxt   = '0;
          state_nxt = ARM;
        end
        ARM: begin
          if (rise) begin
            cnt_nxt   = ONE;
            state_nxt = HIGH;
          end
        end
        HIGH: begin
          if (cnt == TO_LIM) begin
            timeout_nxt = 1'b1;
            locked_nxt  = 1'b0;
            cnt_nxt     = '0;
            state_nxt   = ARM;
          end else if (fall) begin
            high_lat_nxt = cnt;
            cnt_nxt      = cnt_inc;
            state_nxt    = LOW;
          end else begin
            cnt_nxt = cnt_inc;
          end
        end
        LOW: begin
          if (cnt == TO_LIM) begin
            timeout_nxt = 1'b1;
            locked_nxt  = 1'b0;
            cnt_nxt     = '0;
            state_nxt   = ARM;
          end else if (rise) begin
            period_nxt = cnt;
            high_nxt   = high_lat;
            valid_nxt  = 1'b1;
            locked_nxt = 1'b1;
            cnt_nxt    = ONE;
            state_nxt  = HIGH;
          end else begin
            cnt_nxt = cnt_inc;
          end
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pwm_capture_ip.sv
// Scoreboard bench for pwm_capture_ip: expected reports queued as waveforms are driven.
module tb_pwm_capture_ip;

  localparam int CW = 32;
  localparam int TO = 100;
`ifdef PWM_CAPTURE_GLITCH_FILTER_EN
  localparam int EDGE_LAT = 5;
`else
  localparam int EDGE_LAT = 2;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic          enable;
  logic          clear;
  logic          pwm_in;
  logic [CW-1:0] period_cycles_o;
  logic [CW-1:0] high_cycles_o;
  logic          meas_valid;
  logic          timeout;
  logic          level_o;
  logic          locked;

  always #5 clk = ~clk;

  pwm_capture_ip #(
    .CNT_WIDTH      (CW),
    .SYNC_STAGES    (2),
    .TIMEOUT_CYCLES (TO),
    .FILTER_LEN     (3)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .enable          (enable),
    .clear           (clear),
    .pwm_in          (pwm_in),
    .period_cycles_o (period_cycles_o),
    .high_cycles_o   (high_cycles_o),
    .meas_valid      (meas_valid),
    .timeout         (timeout),
    .level_o         (level_o),
    .locked          (locked)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, want);
    end
  endtask

  typedef struct {
    logic [CW-1:0] per;
    logic [CW-1:0] hi;
  } exp_t;

  exp_t exp_q[$];
  bit   seen_rise = 1'b0;
  int   prev_h = 0;
  int   prev_l = 0;
  int   to_cnt = 0;
  int   cyc = 0;
  int   last_vld = -1;
  int   spacing_exp = 0;

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // A rising edge closes the previous full period, if one was in progress.
  task automatic push_prev();
    exp_t e;
    if (seen_rise) begin
      e.per = CW'(prev_h + prev_l);
      e.hi  = CW'(prev_h);
      exp_q.push_back(e);
    end
  endtask

  task automatic period(input int h, input int l);
    push_prev();
    pwm_in = 1'b1;
    tick(h);
    pwm_in = 1'b0;
    tick(l);
    prev_h    = h;
    prev_l    = l;
    seen_rise = 1'b1;
  endtask

  always @(negedge clk) begin
    exp_t e;
    cyc++;
    if (timeout) to_cnt++;
    if (meas_valid) begin
      if (spacing_exp != 0 && last_vld >= 0)
        check("valid_spacing", 64'(cyc - last_vld), 64'(spacing_exp));
      last_vld = cyc;
      if (exp_q.size() == 0) begin
        check("spurious_valid", 64'(meas_valid), 64'(0));
      end else begin
        e = exp_q.pop_front();
        check("period", 64'(period_cycles_o), 64'(e.per));
        check("high", 64'(high_cycles_o), 64'(e.hi));
      end
    end
  end

  initial begin
    rst    = 1'b1;
    enable = 1'b0;
    clear  = 1'b0;
    pwm_in = 1'b0;
    tick(3);
    check("rst_period", 64'(period_cycles_o), 64'(0));
    check("rst_high", 64'(high_cycles_o), 64'(0));
    check("rst_valid", 64'(meas_valid), 64'(0));
    check("rst_timeout", 64'(timeout), 64'(0));
    check("rst_level", 64'(level_o), 64'(0));
    check("rst_locked", 64'(locked), 64'(0));
    rst = 1'b0;
    tick(1);
    enable = 1'b1;
    tick(2);

    // steady 3 high / 5 low
    spacing_exp = 8;
    repeat (4) period(3, 5);
    check("locked_steady", 64'(locked), 64'(1));

    // stuck high after lock
    push_prev();
    pwm_in    = 1'b1;
    seen_rise = 1'b0;
    tick(130);
    spacing_exp = 0;
    check("timeout_once", 64'(to_cnt), 64'(1));
    check("stuck_level", 64'(level_o), 64'(1));
    check("locked_after_to", 64'(locked), 64'(0));
    check("hold_period", 64'(period_cycles_o), 64'(8));
    check("hold_high", 64'(high_cycles_o), 64'(3));
    pwm_in = 1'b0;
    tick(5);

    // disable in the middle of a high phase
    repeat (2) period(3, 5);
    push_prev();
    pwm_in = 1'b1;
    tick(EDGE_LAT + 2);
    enable = 1'b0;
    tick(2);
    check("locked_disable", 64'(locked), 64'(0));
    tick(1);
    enable    = 1'b1;
    pwm_in    = 1'b0;
    seen_rise = 1'b0;
    tick(5);
    repeat (3) period(10, 10);

    // clear on the cycle the rise is detected
    pwm_in = 1'b1;
    tick(EDGE_LAT);
    clear = 1'b1;
    tick(1);
    clear = 1'b0;
    check("clear_period", 64'(period_cycles_o), 64'(0));
    check("clear_high", 64'(high_cycles_o), 64'(0));
    check("clear_locked", 64'(locked), 64'(0));
    tick(10 - EDGE_LAT - 1);
    pwm_in = 1'b0;
    tick(10);
    seen_rise = 1'b0;
    repeat (2) period(10, 10);

    // 2-cycle low glitch inside a 10-cycle high phase
`ifdef PWM_CAPTURE_GLITCH_FILTER_EN
    push_prev();
    pwm_in = 1'b1;
    tick(4);
    pwm_in = 1'b0;
    tick(2);
    pwm_in = 1'b1;
    tick(4);
    pwm_in = 1'b0;
    tick(6);
    prev_h    = 10;
    prev_l    = 6;
    seen_rise = 1'b1;
`else
    period(4, 2);
    period(4, 6);
`endif
    period(10, 6);

    // asynchronous reset in the middle of a low phase
    period(3, 5);
    push_prev();
    pwm_in = 1'b1;
    tick(3);
    pwm_in = 1'b0;
    tick(EDGE_LAT + 3);
    rst = 1'b1;
    #2;
    check("arst_period", 64'(period_cycles_o), 64'(0));
    check("arst_high", 64'(high_cycles_o), 64'(0));
    check("arst_valid", 64'(meas_valid), 64'(0));
    check("arst_timeout", 64'(timeout), 64'(0));
    check("arst_level", 64'(level_o), 64'(0));
    check("arst_locked", 64'(locked), 64'(0));
    tick(2);
    rst       = 1'b0;
    seen_rise = 1'b0;
    tick(2);
    repeat (3) period(3, 5);
    tick(20);

    check("queue_empty", 64'(exp_q.size()), 64'(0));
    check("timeout_total", 64'(to_cnt), 64'(1));
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/pwm_capture_ip.md
# pwm_capture_ip

Input-capture block that measures an external or looped-back PWM waveform. It synchronizes `pwm_in` and detects its edges. It reports period and high-time in `clk` cycles once per completed period. It is the receive-side counterpart of the PWM generator core: a `pwm_core_ip` output fed into this block at period P and duty D must read back as `period_cycles_o = P` and `high_cycles_o = D`. It sits beside the PWM peripheral for closed-loop self-test and for decoding PWM-coded sensor/servo feedback.

## Interface
- `CNT_WIDTH`, 32: width of the measurement counter and result outputs.
- `SYNC_STAGES`, 2: flops in the `pwm_in` synchronizer; minimum 2.
- `TIMEOUT_CYCLES`, 32'd1_000_000: count at which a measurement is abandoned. Must be < 2^CNT_WIDTH − 1.
- `FILTER_LEN`, 3: consecutive agreeing samples required by the glitch filter; minimum 2. Used only when the filter is compiled in.

Ports:
- `clk`  in  1  sole clock.
- `rst`  in  1  asynchronous, active-high reset.
- `enable`  in  1  capture enable; 0 forces IDLE.
- `clear`  in  1  synchronous; zeroes results and re-arms.
- `pwm_in`  in  1  asynchronous PWM input.
- `period_cycles_o`  out  CNT_WIDTH  last measured period (rise to rise).
- `high_cycles_o`  out  CNT_WIDTH  last measured high time (rise to fall).
- `meas_valid`  out  1  one-cycle pulse when both results update.
- `timeout`  out  1  one-cycle pulse when a measurement is abandoned.
- `level_o`  out  1  conditioned input level (post-sync/filter); shows the stuck level on timeout.
- `locked`  out  1  high from the first `meas_valid` until timeout, clear, or disable.

## Operation
- Conditioning: `pwm_in` → SYNC_STAGES flops → optional filter → `lvl`. A `lvl_d` register holds the previous value.
  - `rise` = `lvl & ~lvl_d`.
  - `fall` = `~lvl & lvl_d`.
- FSM states: IDLE, ARM, HIGH, LOW.
  - IDLE: counter = 0. Goes to ARM when `enable` = 1.
  - ARM: waits for `rise`. On `rise`: counter ← 1, go to HIGH.
  - HIGH: counter += 1 each cycle. On `fall`: `high_lat` ← counter, counter += 1, go to LOW.
  - LOW: counter += 1 each cycle. On `rise`:
    - `period_cycles_o` ← counter and `high_cycles_o` ← `high_lat`.
    - Pulse `meas_valid` and set `locked`.
    - counter ← 1, stay measuring (go to HIGH).
- Result: for input high H cycles and low L cycles, `period_cycles_o` = H+L and `high_cycles_o` = H.
- The first partial period after arming is never reported. A first `rise` is always needed.
- Timeout: if counter = TIMEOUT_CYCLES in HIGH or LOW:
  - Pulse `timeout`, clear `locked`, go to ARM.
  - Results hold their last values.
  - This covers 0% and 100% duty: `level_o` shows which.
- Counter arithmetic: unsigned, CNT_WIDTH bits. Timeout fires before the counter can wrap, so it never wraps.
- `enable` = 0 in any state: go to IDLE the next cycle. Counter and `high_lat` are zeroed, `locked` = 0, results hold, and no pulse is emitted.
- `clear` = 1 (while enabled):
  - Results ← 0, `locked` ← 0, go to ARM.
  - `clear` beats a simultaneous `rise`, and `meas_valid` is suppressed.
  - `clear` with `enable` = 0 zeroes the results and stays in IDLE.
- A simultaneous timeout and edge in the same cycle: timeout wins.

## Timing
- Reset values:
  - All outputs 0.
  - State IDLE.
  - Synchronizer, filter and `lvl_d` reset to 0, so an input that is high at reset is seen as a `rise`.
- Latency from a `pwm_in` edge to internal `rise`/`fall`: SYNC_STAGES cycles, plus FILTER_LEN when the filter is in.
- `meas_valid`, `timeout` and the result outputs are registered. They change in the cycle after the detecting cycle and are aligned with each other.
- Minimum resolvable high or low time: 1 cycle without the filter, FILTER_LEN cycles with it.

## Configuration
- Macro: `PWM_CAPTURE_GLITCH_FILTER_EN`.
- Defined: `lvl` changes only after FILTER_LEN consecutive synchronized samples of the new value. Pulses shorter than FILTER_LEN are rejected. Edge latency grows by FILTER_LEN cycles. Steady-state H/L measurements are unchanged because the delay applies equally to both edges.
- Undefined: the filter is absent, `lvl` equals the synchronizer output, and FILTER_LEN is ignored.

## Test plan
- Steady input, H=3 and L=5, repeating: the first `meas_valid` follows the second rising edge, with `period_cycles_o` = 8 and `high_cycles_o` = 3. One pulse follows every 8 cycles after that, and `locked` = 1.
- Input held high after lock, with TIMEOUT_CYCLES = 100: `timeout` pulses exactly once, `level_o` = 1, `locked` = 0, results still read 8/3, and the FSM is in ARM.
- `enable` dropped mid-HIGH, then re-asserted with H=10 and L=10: no `meas_valid` for the aborted period, and the next report is 20/10.
- `clear` asserted on the same cycle as a detected `rise`: no `meas_valid`, results = 0, and the next full period is reported correctly.
- With the filter compiled in (FILTER_LEN = 3), inject a 2-cycle low glitch inside a 10-cycle high phase (H=10, L=6): no extra edge, and the report is 16/10. The same glitch with the filter compiled out yields a short-period report.
- Assert `rst` asynchronously mid-LOW: all outputs are 0 immediately, and after release the first report needs two rising edges.
